// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int CNT_W_DEF       = 28;
    localparam int DEFAULT_DIV_DEF = 2;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Width of a channel index; a single channel still needs a 1-bit selector.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: free-running counter, active/shadow divisor pair with
// end-of-period apply, and registered square-wave and tick outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             sync_clear,
    output logic             div_pending,
    output logic             clock_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] eff_div_s;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] half_s;
    logic             wrap_s;

    // A zero divisor behaves as divide-by-one; all arithmetic stays in CNT_W bits.
    assign eff_div_s = (active_q == {CNT_W{1'b0}}) ? CNT_W'(1) : active_q;
    assign last_s    = eff_div_s - CNT_W'(1);
    assign half_s    = eff_div_s >> 1;
    assign wrap_s    = (cnt_q >= last_s);

    // Next-state: disable beats sync_clear beats normal counting; load is folded in last.
    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_d     = clk_q;
        tick_d    = tick_q;

        if (!enable) begin
            cnt_d  = {CNT_W{1'b0}};
            clk_d  = 1'b0;
            tick_d = 1'b0;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else begin
                active_d  = active_q;
            end
        end else if (sync_clear) begin
            cnt_d  = {CNT_W{1'b0}};
            clk_d  = (cnt_q < half_s);
            tick_d = 1'b0;
        end else begin
            cnt_d  = wrap_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
            clk_d  = (cnt_q < half_s);
            tick_d = wrap_s;
            if (wrap_s && pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end else begin
                active_d  = active_q;
            end
        end

        // A load in the apply cycle keeps the new value waiting for the next wrap.
        if (load) begin
            shadow_d  = div_in;
            pending_d = 1'b1;
        end else begin
            shadow_d  = shadow_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            active_q  <= CNT_W'(DEFAULT_DIV);
            shadow_q  <= CNT_W'(DEFAULT_DIV);
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_pending = pending_q;
    assign clock_out   = clk_q;
    assign tick        = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers sharing one clock, with a
// decoded divisor-load port and a global phase-aligning sync_clear.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                          clock_in,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             enable,
    input  logic                          div_load,
    input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]              div_in,
    input  logic                          sync_clear,
    output logic [NUM_CH-1:0]             div_pending,
    output logic [NUM_CH-1:0]             clock_out,
    output logic [NUM_CH-1:0]             tick
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic load_s;

        // Indices past NUM_CH never match, so such loads are dropped.
        assign load_s = div_load && (div_ch == CH_W'(gi));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in    (clock_in),
            .reset_n     (reset_n),
            .enable      (enable[gi]),
            .load        (load_s),
            .div_in      (div_in),
            .sync_clear  (sync_clear),
            .div_pending (div_pending[gi]),
            .clock_out   (clock_out[gi]),
            .tick        (tick[gi])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: per-cycle comparison against a
// behavioural reference plus hand-computed sequences.
module tb_multi_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 28;
    localparam int DEF    = 2;

    logic              clk;
    logic              reset_n;
    logic [NUM_CH-1:0] enable;
    logic              div_load;
    logic [1:0]        div_ch;
    logic [CNT_W-1:0]  div_in;
    logic              sync_clear;
    logic [NUM_CH-1:0] div_pending;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] tick;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock_in    (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .div_load    (div_load),
        .div_ch      (div_ch),
        .div_in      (div_in),
        .sync_clear  (sync_clear),
        .div_pending (div_pending),
        .clock_out   (clock_out),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: position within the period, divisor pair and pending flag per channel.
    longint            m_pos  [NUM_CH];
    longint            m_act  [NUM_CH];
    longint            m_shad [NUM_CH];
    bit [NUM_CH-1:0]   m_pend, m_clk, m_tick;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_pos[c]  = 0;
                m_act[c]  = DEF;
                m_shad[c] = DEF;
            end
            m_pend = '0;
            m_clk  = '0;
            m_tick = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                longint period;
                bit     last;
                period = (m_act[c] == 0) ? 1 : m_act[c];
                last   = (m_pos[c] + 1 >= period);
                if (!enable[c]) begin
                    m_clk[c]  = 1'b0;
                    m_tick[c] = 1'b0;
                    m_pos[c]  = 0;
                    if (m_pend[c]) begin m_act[c] = m_shad[c]; m_pend[c] = 1'b0; end
                end else begin
                    m_clk[c]  = (2 * m_pos[c] + 2 <= period);
                    m_tick[c] = last && !sync_clear;
                    if (sync_clear)  m_pos[c] = 0;
                    else if (last)   m_pos[c] = 0;
                    else             m_pos[c] = m_pos[c] + 1;
                    if (!sync_clear && last && m_pend[c]) begin
                        m_act[c]  = m_shad[c];
                        m_pend[c] = 1'b0;
                    end
                end
                if (div_load && div_ch == c[1:0]) begin
                    m_shad[c] = longint'(div_in);
                    m_pend[c] = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_clock_out", 32'(clock_out), 32'(m_clk));
            chk("model_tick", 32'(tick), 32'(m_tick));
            chk("model_div_pending", 32'(div_pending), 32'(m_pend));
        end
    end

    task automatic load(input int ch, input int val);
        div_load = 1'b1;
        div_ch   = ch[1:0];
        div_in   = CNT_W'(val);
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_applied(input int ch);
        int n = 0;
        while (div_pending[ch] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("apply_timeout", 32'(div_pending[ch]), 32'd0);
    endtask

    initial begin
        logic [4:0] seq5_c, seq5_t;
        logic [3:0] seq4_c, seq4_t;
        logic       any_out;
        int         n, both, first_both, ch0_ticks;

        reset_n    = 1'b0;
        enable     = 4'hF;
        div_load   = 1'b0;
        div_ch     = 2'd0;
        div_in     = '0;
        sync_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_clock_out", 32'(clock_out), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        reset_n = 1'b1;

        // Default divide-by-2 on all channels.
        @(negedge clk); chk("def_c1", 32'(clock_out), 32'hF); chk("def_t1", 32'(tick), 32'h0);
        @(negedge clk); chk("def_c2", 32'(clock_out), 32'h0); chk("def_t2", 32'(tick), 32'hF);
        @(negedge clk); chk("def_c3", 32'(clock_out), 32'hF); chk("def_t3", 32'(tick), 32'h0);
        chk("def_pending", 32'(div_pending), 32'h0);

        // ch1: D=4, then load 5 while the counter sits at 2.
        load(1, 4);
        wait_applied(1);
        n = 0;
        while (m_pos[1] != 2 && n < 20) begin @(negedge clk); n++; end
        chk("ch1_wait_cnt2", 32'(m_pos[1]), 32'd2);
        load(1, 5);
        chk("ch1_pending_set", 32'(div_pending[1]), 32'd1);
        @(negedge clk);
        chk("ch1_old_wrap_tick", 32'(tick[1]), 32'd1);
        chk("ch1_pending_clr", 32'(div_pending[1]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seq5_c[4-i] = clock_out[1];
            seq5_t[4-i] = tick[1];
        end
        chk("ch1_d5_clock_seq", 32'(seq5_c), 32'b11000);
        chk("ch1_d5_tick_seq", 32'(seq5_t), 32'b00001);

        // ch2: divisors 0 and 1 both mean divide-by-one.
        load(2, 0);
        wait_applied(2);
        repeat (2) @(negedge clk);
        chk("ch2_d0_tick", 32'(tick[2]), 32'd1);
        chk("ch2_d0_clock", 32'(clock_out[2]), 32'd0);
        load(2, 1);
        wait_applied(2);
        repeat (2) @(negedge clk);
        chk("ch2_d1_tick", 32'(tick[2]), 32'd1);
        chk("ch2_d1_clock", 32'(clock_out[2]), 32'd0);

        // ch0: D=4, disable for 7 cycles, re-enable.
        load(0, 4);
        wait_applied(0);
        enable[0] = 1'b0;
        any_out   = 1'b0;
        repeat (7) begin
            @(negedge clk);
            any_out = any_out | clock_out[0] | tick[0];
        end
        chk("ch0_disabled_quiet", 32'(any_out), 32'd0);
        enable[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq4_c[3-i] = clock_out[0];
        end
        chk("ch0_reenable_seq", 32'(seq4_c), 32'b1100);

        // ch0 D=3, ch3 D=6, then sync_clear.
        load(0, 3);
        wait_applied(0);
        load(3, 6);
        wait_applied(3);
        repeat (4) @(negedge clk);
        sync_clear = 1'b1;
        @(negedge clk);
        sync_clear = 1'b0;
        chk("sync_no_tick", 32'(tick & 4'b1001), 32'd0);
        both = 0; first_both = 0; ch0_ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (tick[0]) ch0_ticks++;
            if (tick[0] && tick[3]) begin
                both++;
                if (first_both == 0) first_both = k;
            end
        end
        chk("sync_both_count", 32'(both), 32'd2);
        chk("sync_first_both", 32'(first_both), 32'd6);
        chk("sync_ch0_ticks", 32'(ch0_ticks), 32'd4);

        // Async reset with a divisor pending on ch2.
        load(2, 9);
        wait_applied(2);
        load(2, 3);
        chk("pre_reset_pending", 32'(div_pending[2]), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_clock_out", 32'(clock_out), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_pending", 32'(div_pending), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq4_c[3-i] = clock_out[2];
            seq4_t[3-i] = tick[2];
        end
        chk("post_reset_ch2_clock", 32'(seq4_c), 32'b1010);
        chk("post_reset_ch2_tick", 32'(seq4_t), 32'b0101);
        chk("post_reset_pending", 32'(div_pending), 32'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised successor of the single-channel fixed divider.
- NUM_CH independent divider channels, all clocked from clock_in. Each channel has a per-channel enable and a divisor that is programmable at runtime.
- Each channel produces a square-wave clock_out and a single-cycle tick, used as a clock enable for game logic, pixel timing and sound tones.
- Divisor changes are glitch-free: a new divisor takes effect only at the end of a period. A global sync_clear phase-aligns all channels.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 28, counter and divisor width in bits.
- DEFAULT_DIV, 2, active and shadow divisor of every channel after reset.

Ports:
- clock_in  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  NUM_CH  per-channel run enable.
- div_load  in  1  one-cycle strobe: write div_in to the shadow divisor of channel div_ch.
- div_ch  in  max(1,$clog2(NUM_CH))  target channel index for div_load.
- div_in  in  CNT_W  new divisor value.
- sync_clear  in  1  one-cycle strobe: zero all channel counters.
- div_pending  out  NUM_CH  shadow divisor written but not yet applied.
- clock_out  out  NUM_CH  divided square wave, registered.
- tick  out  NUM_CH  one-cycle pulse per period, registered.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low.
  - While reset_n=0, per channel: cnt=0; active_div=DEFAULT_DIV; shadow_div=DEFAULT_DIV; div_pending=0; clock_out=0; tick=0.
- Effective divisor: D = (active_div==0) ? 1 : active_div.
- Counter, enabled channel: each cycle, if cnt >= D-1 then cnt<=0 (wrap), else cnt<=cnt+1.
  - The >= compare guarantees recovery if cnt ever exceeds D-1.
- Outputs are registered from pre-update cnt (one cycle latency):
  - clock_out <= (cnt < D/2), integer floor. Odd D gives high time floor(D/2) and low time ceil(D/2). D=1 holds clock_out at 0.
  - tick <= (cnt >= D-1), i.e. high for one cycle per D cycles. D=1 gives tick continuously high.
- Disabled channel (enable=0):
  - cnt<=0, clock_out<=0, tick<=0.
  - On re-enable, counting restarts from cnt=0, so the first period is complete.
- div_load:
  - shadow_div[div_ch]<=div_in and div_pending[div_ch]<=1.
  - div_ch >= NUM_CH is ignored.
- Apply: in any cycle where a channel wraps, or is disabled, with div_pending=1:
  - active_div<=shadow_div and div_pending<=0.
  - Active divisor never changes mid-period, so there are no runt pulses.
- Same-cycle load and apply on the same channel:
  - The old shadow (pre-write) is applied.
  - The new value is stored in shadow and div_pending stays 1. It is applied at the next wrap.
- sync_clear, all channels:
  - cnt<=0; tick<=0; clock_out keeps its normal formula.
  - Pending divisors are not applied in that cycle.
- Priority: reset_n > disable > sync_clear > wrap/increment.
- Mid-operation async reset: all state returns to reset values immediately; nothing is preserved.
- Arithmetic: unsigned, CNT_W bits. D-1 and D/2 are computed in CNT_W bits. D up to 2^CNT_W-1 must be supported without overflow.

Decomposition:
- Package clkdiv_pkg holds:
  - CNT_W_DEF=28 and DEFAULT_DIV_DEF=2.
  - Typedef cnt_t (logic [CNT_W-1:0]).
  - Helper function ch_idx_w(NUM_CH).
- Sub-module clkdiv_channel: one channel holding cnt, active/shadow divisor, pending flag, tick and clock_out.
  - Inputs: enable, load strobe (decoded), div_in, sync_clear.
  - Top level instantiates NUM_CH copies through a generate loop and decodes div_ch.

Test Plan:
- Reset release with all enable=1 and DEFAULT_DIV=2: every channel clock_out=1,0,1,0…; tick high every 2nd cycle; div_pending=0.
- Load div_in=5 on ch1 mid-period at cnt=2 of D=4:
  - ch1 div_pending=1 until wrap.
  - The current period stays 4 cycles; then clock_out high 2, low 3; tick period 5.
- Load div_in=0 and div_in=1 on ch2:
  - tick continuously high after apply; clock_out held 0.
- Disable ch0 for 7 cycles, then re-enable with D=4:
  - outputs 0 while disabled.
  - After re-enable, the first clock_out sequence is 1,1,0,0 from cnt=0.
- ch0 D=3 and ch3 D=6 running out of phase, then sync_clear:
  - both restart at cnt=0 in the next cycle; no tick that cycle.
  - ticks coincide every 6 cycles thereafter.
- Assert reset_n low mid-period with div_pending=1 on ch2:
  - outputs drop to 0 asynchronously; pending cleared.
  - After release, D=2 behaviour with no late apply of the stale shadow.
